// File: rtl/cms_ctrl_responder.sv
// CMS control responder: register file, trace-trigger FSM, address-range flag, cycle counter.
// Latency: writes visible next cycle, reads 1 cycle, triggers 1 cycle; no backpressure, every read is answered.
module cms_ctrl_responder #(
    parameter int          XLEN            = 64,
    parameter int          CTRL_ADDR_WIDTH = 8,
    parameter int          CTRL_DATA_WIDTH = 64,
    parameter logic [31:0] WFI_INSTRUCTION = 32'h10500073
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
    input  logic                       ctrl_write_enable,
    input  logic                       ctrl_rd_en,
    output logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata,
    output logic                       ctrl_rvalid,
    input  logic [XLEN-1:0]            pc,
    input  logic [31:0]                instr,
    input  logic                       instr_valid,
    output logic                       trace_active,
    output logic                       wfi_stopped,
    output logic                       addr_in_range,
    output logic [63:0]                clk_counter
);

    localparam int CNT_W = 64;

    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_START_EN   = CTRL_ADDR_WIDTH'(0);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_END_EN     = CTRL_ADDR_WIDTH'(1);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_START_ADDR = CTRL_ADDR_WIDTH'(2);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_END_ADDR   = CTRL_ADDR_WIDTH'(3);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_LO_EN      = CTRL_ADDR_WIDTH'(4);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_HI_EN      = CTRL_ADDR_WIDTH'(5);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_LO_BOUND   = CTRL_ADDR_WIDTH'(6);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_HI_BOUND   = CTRL_ADDR_WIDTH'(7);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_WFI        = CTRL_ADDR_WIDTH'(8);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_CLK_CNT    = CTRL_ADDR_WIDTH'(9);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_LAST_TS    = CTRL_ADDR_WIDTH'(10);

    typedef struct packed {
        logic            start_en;
        logic            end_en;
        logic            lo_en;
        logic            hi_en;
        logic [XLEN-1:0] start_addr;
        logic [XLEN-1:0] end_addr;
        logic [XLEN-1:0] lo_bound;
        logic [XLEN-1:0] hi_bound;
    } cfg_t;

    typedef enum logic [1:0] {
        TRACE_OFF = 2'd0,
        TRACE_ON  = 2'd1,
        WFI_HALT  = 2'd2
    } trace_state_t;

    cfg_t                       r_cfg;
    trace_state_t               r_state;
    trace_state_t               w_state_nxt;
    logic                       r_trace_active;
    logic                       r_wfi_stopped;
    logic                       r_in_range;
    logic [CNT_W-1:0]           r_clk_counter;
    logic [CNT_W-1:0]           r_last_ts;
    logic [CTRL_DATA_WIDTH-1:0] r_rdata;
    logic                       r_rvalid;

    logic                       w_wr_mapped;
    logic                       w_wr_start_en;
    logic                       w_wr_clk_cnt;
    logic                       w_wfi_release;
    logic                       w_is_wfi;
    logic                       w_start_hit;
    logic                       w_end_hit;
    logic                       w_lo_ok;
    logic                       w_hi_ok;
    logic [CTRL_DATA_WIDTH-1:0] w_rd_mux;

    assign w_wr_mapped   = ctrl_write_enable && (ctrl_addr <= ADDR_LAST_TS);
    assign w_wr_start_en = ctrl_write_enable && (ctrl_addr == ADDR_START_EN);
    assign w_wr_clk_cnt  = ctrl_write_enable && (ctrl_addr == ADDR_CLK_CNT);
    assign w_wfi_release = ctrl_write_enable && (ctrl_addr == ADDR_WFI) && !ctrl_wdata[0];
    assign w_is_wfi      = instr_valid && (instr == WFI_INSTRUCTION);

    // Triggers compare against the pre-write configuration of this cycle.
    assign w_start_hit = instr_valid && r_cfg.start_en && (pc == r_cfg.start_addr);
    assign w_end_hit   = instr_valid && r_cfg.end_en   && (pc == r_cfg.end_addr);
    assign w_lo_ok     = !r_cfg.lo_en || (pc >= r_cfg.lo_bound);
    assign w_hi_ok     = !r_cfg.hi_en || (pc <= r_cfg.hi_bound);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TRACE_ON;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority: WFI detect, then control write, then end trigger, then start trigger.
    always_comb begin
        w_state_nxt = r_state;
        if (w_is_wfi) begin
            w_state_nxt = WFI_HALT;
        end else begin
            case (r_state)
                WFI_HALT: begin
                    if (w_wfi_release) begin
                        w_state_nxt = r_cfg.start_en ? TRACE_OFF : TRACE_ON;
                    end
                end
                TRACE_ON: begin
                    if (w_wr_start_en) begin
                        w_state_nxt = ctrl_wdata[0] ? TRACE_OFF : TRACE_ON;
                    end else if (w_end_hit) begin
                        w_state_nxt = TRACE_OFF;
                    end
                end
                TRACE_OFF: begin
                    if (w_wr_start_en) begin
                        w_state_nxt = ctrl_wdata[0] ? TRACE_OFF : TRACE_ON;
                    end else if (w_start_hit) begin
                        w_state_nxt = TRACE_ON;
                    end
                end
                default: w_state_nxt = TRACE_ON;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trace_active <= 1'b1;
            r_wfi_stopped  <= 1'b0;
        end else begin
            r_trace_active <= (w_state_nxt == TRACE_ON);
            r_wfi_stopped  <= (w_state_nxt == WFI_HALT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= '0;
        end else if (ctrl_write_enable) begin
            case (ctrl_addr)
                ADDR_START_EN:   r_cfg.start_en   <= ctrl_wdata[0];
                ADDR_END_EN:     r_cfg.end_en     <= ctrl_wdata[0];
                ADDR_START_ADDR: r_cfg.start_addr <= XLEN'(ctrl_wdata);
                ADDR_END_ADDR:   r_cfg.end_addr   <= XLEN'(ctrl_wdata);
                ADDR_LO_EN:      r_cfg.lo_en      <= ctrl_wdata[0];
                ADDR_HI_EN:      r_cfg.hi_en      <= ctrl_wdata[0];
                ADDR_LO_BOUND:   r_cfg.lo_bound   <= XLEN'(ctrl_wdata);
                ADDR_HI_BOUND:   r_cfg.hi_bound   <= XLEN'(ctrl_wdata);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_counter <= '0;
            r_last_ts     <= '0;
        end else begin
            if (w_wr_clk_cnt) begin
                r_clk_counter <= CNT_W'(ctrl_wdata);
            end else begin
                r_clk_counter <= r_clk_counter + CNT_W'(1);
            end
            if (w_wr_mapped) begin
                r_last_ts <= r_clk_counter;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_range <= 1'b0;
        end else if (instr_valid) begin
            r_in_range <= w_lo_ok && w_hi_ok;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (ctrl_addr)
            ADDR_START_EN:   w_rd_mux = CTRL_DATA_WIDTH'(r_cfg.start_en);
            ADDR_END_EN:     w_rd_mux = CTRL_DATA_WIDTH'(r_cfg.end_en);
            ADDR_START_ADDR: w_rd_mux = CTRL_DATA_WIDTH'(r_cfg.start_addr);
            ADDR_END_ADDR:   w_rd_mux = CTRL_DATA_WIDTH'(r_cfg.end_addr);
            ADDR_LO_EN:      w_rd_mux = CTRL_DATA_WIDTH'(r_cfg.lo_en);
            ADDR_HI_EN:      w_rd_mux = CTRL_DATA_WIDTH'(r_cfg.hi_en);
            ADDR_LO_BOUND:   w_rd_mux = CTRL_DATA_WIDTH'(r_cfg.lo_bound);
            ADDR_HI_BOUND:   w_rd_mux = CTRL_DATA_WIDTH'(r_cfg.hi_bound);
            ADDR_WFI:        w_rd_mux = CTRL_DATA_WIDTH'(r_wfi_stopped);
            ADDR_CLK_CNT:    w_rd_mux = CTRL_DATA_WIDTH'(r_clk_counter);
            ADDR_LAST_TS:    w_rd_mux = CTRL_DATA_WIDTH'(r_last_ts);
            default:         w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= ctrl_rd_en;
            if (ctrl_rd_en) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign ctrl_rdata    = r_rdata;
    assign ctrl_rvalid   = r_rvalid;
    assign trace_active  = r_trace_active;
    assign wfi_stopped   = r_wfi_stopped;
    assign addr_in_range = r_in_range;
    assign clk_counter   = r_clk_counter;

endmodule

// File: tb/tb_cms_ctrl_responder.sv
// Bench for cms_ctrl_responder: directed steps then random traffic, checked against a register-level model.
module tb_cms_ctrl_responder;

    localparam logic [31:0] WFI = 32'h10500073;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int M_OFF  = 0;
    localparam int M_ON   = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  ctrl_addr = '0;
    logic [63:0] ctrl_wdata = '0;
    logic        ctrl_write_enable = 1'b0;
    logic        ctrl_rd_en = 1'b0;
    logic [63:0] ctrl_rdata;
    logic        ctrl_rvalid;
    logic [63:0] pc = '0;
    logic [31:0] instr = NOP;
    logic        instr_valid = 1'b0;
    logic        trace_active;
    logic        wfi_stopped;
    logic        addr_in_range;
    logic [63:0] clk_counter;

    cms_ctrl_responder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ctrl_addr         (ctrl_addr),
        .ctrl_wdata        (ctrl_wdata),
        .ctrl_write_enable (ctrl_write_enable),
        .ctrl_rd_en        (ctrl_rd_en),
        .ctrl_rdata        (ctrl_rdata),
        .ctrl_rvalid       (ctrl_rvalid),
        .pc                (pc),
        .instr             (instr),
        .instr_valid       (instr_valid),
        .trace_active      (trace_active),
        .wfi_stopped       (wfi_stopped),
        .addr_in_range     (addr_in_range),
        .clk_counter       (clk_counter)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference state: register file as an array, mode as a plain number.
    logic [63:0] m_regs [0:7];
    logic [63:0] m_ts, m_cnt, m_rdata;
    logic        m_rvalid, m_inr;
    int          m_mode;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_ts = '0; m_cnt = '0; m_rdata = '0;
        m_rvalid = 1'b0; m_inr = 1'b0; m_mode = M_ON;
    endtask

    function automatic logic [63:0] model_read(input int a);
        if (a <= 7)  return m_regs[a];
        if (a == 8)  return (m_mode == M_HALT) ? 64'd1 : 64'd0;
        if (a == 9)  return m_cnt;
        if (a == 10) return m_ts;
        return 64'd0;
    endfunction

    task automatic model_step();
        int a;
        int nm;
        a = int'(ctrl_addr);
        m_rvalid = ctrl_rd_en;
        if (ctrl_rd_en) m_rdata = model_read(a);
        nm = m_mode;
        if (instr_valid && instr == WFI) nm = M_HALT;
        else if (m_mode == M_HALT) begin
            if (ctrl_write_enable && a == 8 && !ctrl_wdata[0]) nm = m_regs[0][0] ? M_OFF : M_ON;
        end else if (ctrl_write_enable && a == 0) nm = ctrl_wdata[0] ? M_OFF : M_ON;
        else if (instr_valid && m_mode == M_ON && m_regs[1][0] && pc == m_regs[3]) nm = M_OFF;
        else if (instr_valid && m_mode == M_OFF && m_regs[0][0] && pc == m_regs[2]) nm = M_ON;
        m_mode = nm;
        if (instr_valid)
            m_inr = (!m_regs[4][0] || pc >= m_regs[6]) && (!m_regs[5][0] || pc <= m_regs[7]);
        if (ctrl_write_enable && a <= 10) begin
            m_ts = m_cnt;
            if (a == 0 || a == 1 || a == 4 || a == 5) m_regs[a] = {63'd0, ctrl_wdata[0]};
            else if (a <= 7) m_regs[a] = ctrl_wdata;
        end
        if (ctrl_write_enable && a == 9) m_cnt = ctrl_wdata;
        else m_cnt = m_cnt + 64'd1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":trace_active"},  64'(trace_active),  64'(m_mode == M_ON));
        chk({where, ":wfi_stopped"},   64'(wfi_stopped),   64'(m_mode == M_HALT));
        chk({where, ":addr_in_range"}, 64'(addr_in_range), 64'(m_inr));
        chk({where, ":clk_counter"},   clk_counter,        m_cnt);
        chk({where, ":rvalid"},        64'(ctrl_rvalid),   64'(m_rvalid));
        chk({where, ":rdata"},         ctrl_rdata,         m_rdata);
    endtask

    task automatic cycle(input string where);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_outputs(where);
    endtask

    task automatic idle();
        ctrl_write_enable = 1'b0; ctrl_rd_en = 1'b0; instr_valid = 1'b0; instr = NOP;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        ctrl_addr = a; ctrl_wdata = d; ctrl_write_enable = 1'b1;
        cycle("wr");
        idle();
    endtask

    task automatic rd(input logic [7:0] a);
        ctrl_addr = a; ctrl_rd_en = 1'b1;
        cycle("rd");
        idle();
    endtask

    task automatic exec(input logic [63:0] p, input logic [31:0] ins);
        pc = p; instr = ins; instr_valid = 1'b1;
        cycle("exec");
        idle();
    endtask

    function automatic logic [63:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 64'h8000_0100;
            1: return 64'h8000_0200;
            2: return 64'h1000;
            3: return 64'h1FFF;
            4: return {32'h0, $urandom_range(0, 15)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            if ($urandom_range(0, 3) == 0) begin
                ctrl_write_enable = 1'b1;
                ctrl_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(11, 255)) : 8'($urandom_range(0, 10));
                ctrl_wdata = ($urandom_range(0, 1) == 0) ? {63'd0, 1'($urandom)} : pick_val();
                if (ctrl_addr == 8'd9 && $urandom_range(0, 3) != 0) ctrl_wdata = pick_val();
            end
            if ($urandom_range(0, 2) == 0) begin
                ctrl_rd_en = 1'b1;
                if (!ctrl_write_enable || $urandom_range(0, 1) == 0)
                    ctrl_addr = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            end
            if ($urandom_range(0, 1) == 0) begin
                instr_valid = 1'b1;
                pc    = pick_val();
                instr = ($urandom_range(0, 29) == 0) ? WFI : NOP;
            end
            cycle("rand");
        end
        idle();
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_outputs("reset");
        cycle("reset_hold");
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) cycle("count");
        rd(8'd9);
        rd(8'd200);
        chk("rd200_rvalid", 64'(ctrl_rvalid), 64'd1);
        chk("rd200_zero", ctrl_rdata, 64'd0);

        wr(8'd2, 64'h8000_0100);
        wr(8'd3, 64'h8000_0200);
        wr(8'd0, 64'd1);
        chk("armed_off", 64'(trace_active), 64'd0);
        exec(64'h8000_0100, NOP);
        chk("start_hit", 64'(trace_active), 64'd1);
        wr(8'd1, 64'd1);
        exec(64'h8000_0200, NOP);
        chk("end_hit", 64'(trace_active), 64'd0);

        exec(64'h8000_0300, WFI);
        chk("wfi_halt", 64'(wfi_stopped), 64'd1);
        wr(8'd0, 64'd1);
        chk("halt_ignores_start_en", 64'(wfi_stopped), 64'd1);
        wr(8'd8, 64'd0);
        chk("release_to_off", 64'(trace_active), 64'd0);
        exec(64'h8000_0300, WFI);
        wr(8'd0, 64'd0);
        wr(8'd8, 64'd0);
        chk("release_to_on", 64'(trace_active), 64'd1);

        wr(8'd6, 64'h1000);
        wr(8'd7, 64'h1FFF);
        wr(8'd4, 64'd1);
        wr(8'd5, 64'd1);
        exec(64'h1000, NOP);
        chk("lo_edge_in", 64'(addr_in_range), 64'd1);
        exec(64'h2000, NOP);
        chk("above_hi", 64'(addr_in_range), 64'd0);
        exec(64'h1FFF, NOP);
        chk("hi_edge_in", 64'(addr_in_range), 64'd1);
        wr(8'd4, 64'd0);
        exec(64'h0, NOP);
        chk("lo_disabled", 64'(addr_in_range), 64'd1);

        wr(8'd9, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle("wrap");
        cycle("wrap");
        chk("counter_wrap", clk_counter, 64'd0);
        wr(8'd9, 64'd4);
        cycle("ts_setup");
        wr(8'd3, 64'h1234);
        rd(8'd10);
        chk("ts_is_5", ctrl_rdata, 64'd5);
        wr(8'd50, 64'hDEAD);
        rd(8'd10);
        chk("ts_unmapped", ctrl_rdata, 64'd5);

        ctrl_addr = 8'd0; ctrl_wdata = 64'd0; ctrl_write_enable = 1'b1;
        pc = 64'h40; instr = WFI; instr_valid = 1'b1;
        cycle("wfi_vs_write");
        idle();
        chk("wfi_beats_write", 64'(wfi_stopped), 64'd1);
        wr(8'd8, 64'd0);

        random_phase(1500);

        #3 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("async_reset");
        cycle("reset_hold2");
        rst_n = 1'b1;
        random_phase(400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
